// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_pkg
// Description : Shared types and constants for the comp_2_bit magnitude
//               comparator and its cascade cell.
//                 cmp_res_t     - one-hot result, packed as {Eq, Lt, Gt}
//                 CMP_MAX_WIDTH - widest operand the comparator supports
//                 CMP_RESET_RES - result register value before any sample
// Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

  typedef enum logic [2:0] {
    EQ = 3'b100,
    LT = 3'b010,
    GT = 3'b001
  } cmp_res_t;

  localparam int          CMP_MAX_WIDTH = 16;
  localparam logic [2:0]  CMP_RESET_RES = 3'b000;

endpackage : comp_pkg
`default_nettype wire

// File: rtl/comp_cell.sv
`default_nettype none
// ============================================================================
// Module      : comp_cell
// Description : One-bit stage of an MSB-first magnitude compare cascade.
//               A stage that sees an undecided upstream and a differing bit
//               pair makes the decision; otherwise it forwards upstream.
// Ports       : a, b     - operand bits for this position
//               invert   - 1 on the sign bit of a two's-complement compare
//               dec_in   - upstream already decided
//               res_in   - upstream result ({Eq,Lt,Gt}, EQ when undecided)
//               dec_out  - decided at or above this position
//               res_out  - result at or above this position
// Revision    : 1.0 - initial release
// ============================================================================
module comp_cell
  import comp_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       invert,
  input  logic       dec_in,
  input  logic [2:0] res_in,
  output logic       dec_out,
  output logic [2:0] res_out
);

  always_comb begin
    dec_out = dec_in;
    res_out = res_in;
    if (!dec_in && (a != b)) begin
      dec_out = 1'b1;
      // On the sign bit a 1 means negative, so the winner flips.
      res_out = (a ^ invert) ? GT : LT;
    end
  end

endmodule : comp_cell
`default_nettype wire

// File: rtl/comp_2_bit.sv
`default_nettype none
// ============================================================================
// Module      : comp_2_bit
// Description : Registered magnitude comparator. A and B are sampled on a
//               rising clk edge with in_valid high; one-hot Eq/Lt/Gt and a
//               one-cycle out_valid follow one cycle later. Flags hold while
//               in_valid is low.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               A, B      - WIDTH-bit operands
//               in_valid  - sample A/B on this edge
//               Eq/Lt/Gt  - registered compare result of A relative to B
//               out_valid - flags reflect a newly sampled pair
// Parameters  : WIDTH  - operand width, 1..CMP_MAX_WIDTH
//               SIGNED - 0 unsigned, 1 two's-complement
// Revision    : 1.0 - initial release
// ============================================================================
module comp_2_bit
  import comp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             Eq,
  output logic             Lt,
  output logic             Gt,
  output logic             out_valid
);

  // Chain index WIDTH is the cascade head; index 0 is the final result.
  logic [WIDTH:0] w_dec_chain;
  logic [2:0]     w_res_chain [WIDTH:0];

  assign w_dec_chain[WIDTH] = 1'b0;
  assign w_res_chain[WIDTH] = EQ;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      localparam logic C_INVERT = (SIGNED != 0) && (i == WIDTH - 1);

      comp_cell u_cell (
        .a       (A[i]),
        .b       (B[i]),
        .invert  (C_INVERT),
        .dec_in  (w_dec_chain[i+1]),
        .res_in  (w_res_chain[i+1]),
        .dec_out (w_dec_chain[i]),
        .res_out (w_res_chain[i])
      );
    end
  endgenerate

  logic [2:0] res_d;
  logic [2:0] res_q;
  logic       valid_d;
  logic       valid_q;

  always_comb begin
    res_d   = res_q;
    valid_d = in_valid;
    if (in_valid) begin
      res_d = w_res_chain[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= CMP_RESET_RES;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign {Eq, Lt, Gt} = res_q;
  assign out_valid    = valid_q;

endmodule : comp_2_bit
`default_nettype wire

// File: tb/tb_comp_2_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_2_bit
// Description : Self-checking bench for comp_2_bit. One unsigned and one
//               signed instance (WIDTH=2) share stimulus; checks compare the
//               packed {Eq,Lt,Gt,out_valid} of each against expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_2_bit;

  logic       clk;
  logic       rst_n;
  logic [1:0] A;
  logic [1:0] B;
  logic       in_valid;
  logic       eq_u, lt_u, gt_u, ov_u;
  logic       eq_s, lt_s, gt_s, ov_s;

  int n_tests = 0;
  int n_fail  = 0;

  comp_2_bit #(.WIDTH(2), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
    .Eq(eq_u), .Lt(lt_u), .Gt(gt_u), .out_valid(ov_u)
  );

  comp_2_bit #(.WIDTH(2), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
    .Eq(eq_s), .Lt(lt_s), .Gt(gt_s), .out_valid(ov_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] got;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 2'b00;
    B        = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A        = 2'(i);
      B        = 2'(3 - i);
      in_valid = ~in_valid;
      @(posedge clk); #1;
      got = {eq_u, lt_u, gt_u, ov_u};
      n_tests++;
      if (got !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold_u[%0d]: got %b want 0000", i, got);
      end
      got = {eq_s, lt_s, gt_s, ov_s};
      n_tests++;
      if (got !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold_s[%0d]: got %b want 0000", i, got);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = {eq_u, lt_u, gt_u, ov_u};
      n_tests++;
      if (got !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %b want 0000", i, got);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_unsigned_sweep();
    logic [1:0] va [7];
    logic [1:0] vb [7];
    logic [3:0] ve [7];
    logic [3:0] got;
    va = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    vb = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    ve = '{4'b1001, 4'b0101, 4'b0011, 4'b1001, 4'b0101, 4'b0011, 4'b1001};
    for (int i = 0; i < 7; i++) begin
      A        = va[i];
      B        = vb[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      got = {eq_u, lt_u, gt_u, ov_u};
      n_tests++;
      if (got !== ve[i]) begin
        n_fail++;
        $display("FAIL unsigned_sweep A=%b B=%b: got %b want %b", va[i], vb[i], got, ve[i]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_exhaustive();
    logic [3:0] got_u, got_s, exp_u, exp_s;
    int sa, sb;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        A        = 2'(a);
        B        = 2'(b);
        in_valid = 1'b1;
        sa = (a >= 2) ? a - 4 : a;
        sb = (b >= 2) ? b - 4 : b;
        exp_u = (a == b) ? 4'b1001 : (a < b) ? 4'b0101 : 4'b0011;
        exp_s = (sa == sb) ? 4'b1001 : (sa < sb) ? 4'b0101 : 4'b0011;
        @(posedge clk); #1;
        got_u = {eq_u, lt_u, gt_u, ov_u};
        got_s = {eq_s, lt_s, gt_s, ov_s};
        n_tests++;
        if (got_u !== exp_u) begin
          n_fail++;
          $display("FAIL exhaustive_u A=%0d B=%0d: got %b want %b", a, b, got_u, exp_u);
        end
        n_tests++;
        if (got_s !== exp_s) begin
          n_fail++;
          $display("FAIL exhaustive_s A=%0d B=%0d: got %b want %b", a, b, got_s, exp_s);
        end
        n_tests++;
        if ($countones({eq_u, lt_u, gt_u}) != 1) begin
          n_fail++;
          $display("FAIL onehot_u A=%0d B=%0d: got %b want one bit set", a, b, got_u[3:1]);
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic [3:0] got;
    A        = 2'b11;
    B        = 2'b10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    got = {eq_u, lt_u, gt_u, ov_u};
    n_tests++;
    if (got !== 4'b0011) begin
      n_fail++;
      $display("FAIL hold_sample: got %b want 0011", got);
    end
    @(negedge clk);
    A        = 2'b00;
    B        = 2'b11;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = {eq_u, lt_u, gt_u, ov_u};
      n_tests++;
      if (got !== 4'b0010) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %b want 0010", i, got);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_signed();
    logic [1:0] va [3];
    logic [1:0] vb [3];
    logic [3:0] es [3];
    logic [3:0] eu [3];
    logic [3:0] got;
    va = '{2'b10, 2'b11, 2'b01};
    vb = '{2'b01, 2'b10, 2'b11};
    es = '{4'b0101, 4'b0011, 4'b0011};
    eu = '{4'b0011, 4'b0011, 4'b0101};
    for (int i = 0; i < 3; i++) begin
      A        = va[i];
      B        = vb[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      got = {eq_s, lt_s, gt_s, ov_s};
      n_tests++;
      if (got !== es[i]) begin
        n_fail++;
        $display("FAIL signed A=%b B=%b: got %b want %b", va[i], vb[i], got, es[i]);
      end
      got = {eq_u, lt_u, gt_u, ov_u};
      n_tests++;
      if (got !== eu[i]) begin
        n_fail++;
        $display("FAIL signed_vs_unsigned A=%b B=%b: got %b want %b", va[i], vb[i], got, eu[i]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    A        = 2'b00;
    B        = 2'b01;
    in_valid = 1'b1;
    @(posedge clk); #1;
    got = {eq_u, lt_u, gt_u, ov_u};
    n_tests++;
    if (got !== 4'b0101) begin
      n_fail++;
      $display("FAIL async_pre: got %b want 0101", got);
    end
    #1;
    rst_n = 1'b0;
    #1;
    got = {eq_u, lt_u, gt_u, ov_u};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_immediate: got %b want 0000", got);
    end
    // Keep in_valid high across an edge in reset: nothing may come out.
    @(posedge clk); #1;
    got = {eq_u, lt_u, gt_u, ov_u};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_held: got %b want 0000", got);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    A        = 2'b01;
    B        = 2'b01;
    in_valid = 1'b1;
    @(posedge clk); #1;
    got = {eq_u, lt_u, gt_u, ov_u};
    n_tests++;
    if (got !== 4'b1001) begin
      n_fail++;
      $display("FAIL async_recover: got %b want 1001", got);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (ov_u !== 1'b0) begin
      n_fail++;
      $display("FAIL async_ov_drop: got %b want 0", ov_u);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned_sweep();
    test_exhaustive();
    test_hold();
    test_signed();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_comp_2_bit
`default_nettype wire
